led_counter_display: RTL and testbench

Parametrised board-demo core for the Nexys3 LED/7-segment test designs. A single-clock prescaler drives a mode-selectable counter (hold, up, down, ping-pong). Its low bits go to the LEDs, gated by a switch mask. Its low 16 bits are shown as four multiplexed hex digits. The block replaces the fixed divide-by-2^22 derived clock with clock-enable ticks, and adds configurable widths, direction modes and a live display.

---
 rtl/led_counter_display.sv | 156 +++++++++++++++
 tb/tb_led_counter_display.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_counter_display.sv
// rtl/led_counter_display.sv - prescaled hold/up/down/ping-pong counter driving masked LEDs
// and a four-digit multiplexed hex display; all timing via clock-enable ticks on clk.
module led_counter_display #(
  parameter int DIV_MAX   = 4194303,
  parameter int SCAN_MAX  = 65535,
  parameter int CNT_WIDTH = 16,
  parameter int LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [LED_WIDTH-1:0] Sw,
  output logic [LED_WIDTH-1:0] Led,
  output logic [7:0]           seg,
  output logic [3:0]           an
);

  localparam int PW = $clog2(DIV_MAX + 1);
  localparam int SW = $clog2(SCAN_MAX + 1);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_PING = 2'b11
  } mode_e;

  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 dir_q, dir_d;
  logic [1:0]           dig_q, dig_d;
  logic                 den_q, den_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [7:0]           seg_q, seg_d;
  logic [3:0]           an_q, an_d;
  logic                 tick, stick;
  logic [15:0]          disp;
  logic [3:0]           nib;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  // Narrow counters are zero-extended so the upper digits read as 0.
  if (CNT_WIDTH >= 16) begin : g_disp_wide
    assign disp = count_q[15:0];
  end else begin : g_disp_narrow
    assign disp = {{(16 - CNT_WIDTH){1'b0}}, count_q};
  end

  assign tick  = (pcnt_q == PW'(DIV_MAX));
  assign stick = (scnt_q == SW'(SCAN_MAX));

  always_comb begin
    pcnt_d  = tick  ? '0 : pcnt_q + PW'(1);
    scnt_d  = stick ? '0 : scnt_q + SW'(1);
    count_d = count_q;
    dir_d   = dir_q;
    dig_d   = stick ? dig_q + 2'd1 : dig_q;
    den_d   = den_q | stick;
    if (tick) begin
      case (mode_e'(mode))
        MODE_UP: begin
          dir_d   = 1'b0;
          count_d = count_q + CNT_WIDTH'(1);
        end
        MODE_DOWN: begin
          dir_d   = 1'b1;
          count_d = count_q - CNT_WIDTH'(1);
        end
        MODE_PING: begin
          if (!dir_q) begin
            if (count_q == '1) begin
              count_d = count_q - CNT_WIDTH'(1);
              dir_d   = 1'b1;
            end else begin
              count_d = count_q + CNT_WIDTH'(1);
            end
          end else begin
            if (count_q == '0) begin
              count_d = CNT_WIDTH'(1);
              dir_d   = 1'b0;
            end else begin
              count_d = count_q - CNT_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (dig_q)
      2'd0:    nib = disp[3:0];
      2'd1:    nib = disp[7:4];
      2'd2:    nib = disp[11:8];
      default: nib = disp[15:12];
    endcase
    led_d = count_q[LED_WIDTH-1:0] & Sw;
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (den_q) begin
      an_d        = ~(4'b0001 << dig_q);
      seg_d[6:0]  = hex_glyph(nib);
      seg_d[7]    = !((dig_q == 2'd0) && dir_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q  <= '0;
      scnt_q  <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      dig_q   <= 2'd0;
      den_q   <= 1'b0;
      led_q   <= '0;
      seg_q   <= 8'hFF;
      an_q    <= 4'hF;
    end else begin
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      dig_q   <= dig_d;
      den_q   <= den_d;
      led_q   <= led_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign Led = led_q;
  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_led_counter_display.sv
// tb/tb_led_counter_display.sv - directed bench for led_counter_display with a per-edge
// reference model feeding an expected-output queue.
module tb_led_counter_display;

  localparam int DIV  = 3;
  localparam int SCAN = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode;
  logic [7:0] Sw;
  logic [7:0] Led;
  logic [7:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] led;
    logic [7:0] seg;
    logic [3:0] an;
  } out_t;

  out_t sbq[$];

  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  int         m_pcnt, m_scnt;
  logic [7:0] m_count;
  logic       m_dir, m_den;
  logic [1:0] m_dig;

  led_counter_display #(
    .DIV_MAX  (DIV),
    .SCAN_MAX (SCAN),
    .CNT_WIDTH(8),
    .LED_WIDTH(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mode(mode),
    .Sw  (Sw),
    .Led (Led),
    .seg (seg),
    .an  (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pcnt  = 0;
    m_scnt  = 0;
    m_count = 8'h00;
    m_dir   = 1'b0;
    m_dig   = 2'd0;
    m_den   = 1'b0;
  endtask

  // Expected outputs after the coming edge, then advance model state across it.
  task automatic model_edge();
    out_t        e;
    logic [15:0] disp;
    logic [3:0]  n;
    bit          tk, stk;
    tk    = (m_pcnt == DIV);
    stk   = (m_scnt == SCAN);
    e.led = m_count & Sw;
    if (m_den) begin
      disp  = {8'h00, m_count};
      n     = disp[4*m_dig +: 4];
      e.an  = ~(4'b0001 << m_dig);
      e.seg = GLYPH[n];
      if (m_dig == 2'd0 && m_dir) e.seg[7] = 1'b0;
    end else begin
      e.an  = 4'hF;
      e.seg = 8'hFF;
    end
    sbq.push_back(e);
    m_pcnt = tk ? 0 : m_pcnt + 1;
    m_scnt = stk ? 0 : m_scnt + 1;
    if (tk) begin
      case (mode)
        2'b01: begin m_dir = 1'b0; m_count = m_count + 8'd1; end
        2'b10: begin m_dir = 1'b1; m_count = m_count - 8'd1; end
        2'b11: begin
          if (!m_dir) begin
            if (m_count == 8'hFF) begin m_count = 8'hFE; m_dir = 1'b1; end
            else m_count = m_count + 8'd1;
          end else begin
            if (m_count == 8'h00) begin m_count = 8'h01; m_dir = 1'b0; end
            else m_count = m_count - 8'd1;
          end
        end
        default: ;
      endcase
    end
    if (stk) begin
      m_dig = m_dig + 2'd1;
      m_den = 1'b1;
    end
  endtask

  task automatic step();
    out_t e;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    e = sbq.pop_front();
    chk("sb", {12'h0, Led, seg, an}, {12'h0, e.led, e.seg, e.an});
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_led"}, {24'h0, Led}, 32'h00);
    chk({tag, "_an"},  {28'h0, an},  32'hF);
    chk({tag, "_seg"}, {24'h0, seg}, 32'hFF);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_an(input string tag, input logic [3:0] target);
    int k;
    k = 0;
    while (an !== target && k < 40) begin
      step();
      k++;
    end
    chk({tag, "_reached"}, {28'h0, an}, {28'h0, target});
  endtask

  logic [3:0] an_tab  [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [7:0] seg_tab [4] = '{8'h88, 8'hC0, 8'hC0, 8'h92};

  initial begin
    mode = 2'b00;
    Sw   = 8'h00;
    #1 rst = 1'b1;
    #1;
    chk("rst_led", {24'h0, Led}, 32'h00);
    chk("rst_an",  {28'h0, an},  32'hF);
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Up count and 8-bit wrap
    mode = 2'b01;
    Sw   = 8'hFF;
    run(4);
    chk("up_edge4_led", {24'h0, Led}, 32'h00);
    step();
    chk("up_edge5_led", {24'h0, Led}, 32'h01);
    run(1016);
    chk("up_ff", {24'h0, Led}, 32'hFF);
    run(4);
    chk("up_wrap", {24'h0, Led}, 32'h00);

    // Down wrap and dp on digit 0
    reset_pulse("rst2");
    mode = 2'b10;
    run(4);
    mode = 2'b00;
    step();
    chk("down_led", {24'h0, Led}, 32'hFF);
    wait_an("down_dig0", 4'b1110);
    chk("down_seg", {24'h0, seg}, 32'h0E);

    // Ping-pong bounce at both ends, hold preserves direction
    reset_pulse("rst3");
    mode = 2'b11;
    run(1021);
    chk("pp_ff", {24'h0, Led}, 32'hFF);
    run(4);
    chk("pp_fe", {24'h0, Led}, 32'hFE);
    run(4);
    chk("pp_fd", {24'h0, Led}, 32'hFD);
    mode = 2'b00;
    run(20);
    chk("pp_hold", {24'h0, Led}, 32'hFD);
    mode = 2'b11;
    run(4);
    chk("pp_dir_kept", {24'h0, Led}, 32'hFC);
    run(1008);
    chk("pp_zero", {24'h0, Led}, 32'h00);
    run(4);
    chk("pp_bounce", {24'h0, Led}, 32'h01);
    run(4);
    chk("pp_up2", {24'h0, Led}, 32'h02);

    // Mask follows Sw with one edge of latency
    reset_pulse("rst4");
    mode = 2'b01;
    Sw   = 8'hFF;
    run(660);
    mode = 2'b00;
    step();
    chk("mask_a5", {24'h0, Led}, 32'hA5);
    Sw = 8'h0F;
    step();
    chk("mask_0f", {24'h0, Led}, 32'h05);
    Sw = 8'hF0;
    step();
    chk("mask_f0", {24'h0, Led}, 32'hA0);

    // Display scan of held 0xA5, each digit for two clocks
    wait_an("scan_sync", 4'b1101);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("scan_an%0d_%0d", i, j), {28'h0, an}, {28'h0, an_tab[i]});
        chk($sformatf("scan_seg%0d_%0d", i, j), {24'h0, seg}, {24'h0, seg_tab[i]});
        step();
      end
    end

    // Async reset mid-run, then prescaler restart
    reset_pulse("rst5");
    Sw   = 8'hFF;
    mode = 2'b01;
    run(360);
    mode = 2'b00;
    step();
    chk("pre_rst_led", {24'h0, Led}, 32'h5A);
    reset_pulse("rst_mid");
    mode = 2'b01;
    run(4);
    chk("restart_edge4", {24'h0, Led}, 32'h00);
    step();
    chk("restart_edge5", {24'h0, Led}, 32'h01);
    run(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
